extend_pipe: RTL and testbench

- Registered, parametrised immediate generator for the decode stage of the pipelined RISC-V core.
- Builds the sign-extended immediate from instruction bits [31:7] for types I/S/B/J/U, extended to XLEN.
- Carries a pass-through tag (e.g. PC) alongside the immediate.
- Sits between fetch/decode and the execute stage register, with a valid/ready handshake, a 2-entry skid buffer and a flush input.

---
 rtl/riscv_imm_pkg.sv | 20 ++
 rtl/imm_decode.sv | 44 ++++
 rtl/extend_pipe.sv | 130 +++++++++++++
 tb/tb_extend_pipe.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_imm_pkg.sv
// Shared immediate-type codes and skid occupancy encoding for the decode-stage immediate pipe.
package riscv_imm_pkg;

  localparam int unsigned INSTR_W  = 25;
  localparam int unsigned IMMSRC_W = 3;

  localparam logic [IMMSRC_W-1:0] IMM_I   = 3'b000;
  localparam logic [IMMSRC_W-1:0] IMM_S   = 3'b001;
  localparam logic [IMMSRC_W-1:0] IMM_B   = 3'b010;
  localparam logic [IMMSRC_W-1:0] IMM_J   = 3'b011;
  localparam logic [IMMSRC_W-1:0] IMM_U   = 3'b100;
  localparam logic [IMMSRC_W-1:0] IMM_CSR = 3'b101;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

endpackage

// File: rtl/imm_decode.sv
// Combinational RISC-V immediate extender over instruction bits [31:7].
// CSR uimm (immsrc 101) is decoded only when EXTEND_PIPE_CSR_UIMM_EN is defined.
module imm_decode
  import riscv_imm_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [INSTR_W-1:0]  instr_i,
  input  logic [IMMSRC_W-1:0] immsrc_i,
  output logic [XLEN-1:0]     imm_o,
  output logic                illegal_o
);

  // instr_i[k] holds instruction bit k+7
  logic [31:0] imm32;

  always_comb begin
    imm32     = '0;
    illegal_o = 1'b0;
    case (immsrc_i)
      IMM_I:   imm32 = {{20{instr_i[24]}}, instr_i[24:13]};
      IMM_S:   imm32 = {{20{instr_i[24]}}, instr_i[24:18], instr_i[4:0]};
      IMM_B:   imm32 = {{19{instr_i[24]}}, instr_i[24], instr_i[0], instr_i[23:18],
                        instr_i[4:1], 1'b0};
      IMM_J:   imm32 = {{11{instr_i[24]}}, instr_i[24], instr_i[12:5], instr_i[13],
                        instr_i[23:14], 1'b0};
      IMM_U:   imm32 = {instr_i[24:5], 12'b0};
`ifdef EXTEND_PIPE_CSR_UIMM_EN
      IMM_CSR: imm32 = {27'b0, instr_i[12:8]};
`endif
      default: begin
        imm32     = '0;
        illegal_o = 1'b1;
      end
    endcase
  end

  // Every format is sign-extended from bit 31; CSR uimm has bit 31 clear so it zero-extends
  always_comb begin
    imm_o       = {XLEN{imm32[31]}};
    imm_o[31:0] = imm32;
  end

endmodule

// File: rtl/extend_pipe.sv
// Registered immediate generator with valid/ready handshake and a 2-entry skid buffer.
// Optional CSR uimm decode enabled by defining EXTEND_PIPE_CSR_UIMM_EN.
module extend_pipe
  import riscv_imm_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [INSTR_W-1:0]  in_instr,
  input  logic [IMMSRC_W-1:0] in_immsrc,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_imm,
  output logic [TAG_W-1:0]    out_tag,
  output logic                out_illegal
);

  occ_e             state_q, state_d;
  logic [XLEN-1:0]  main_imm_q, main_imm_d;
  logic [TAG_W-1:0] main_tag_q, main_tag_d;
  logic             main_ill_q, main_ill_d;
  logic [XLEN-1:0]  skid_imm_q, skid_imm_d;
  logic [TAG_W-1:0] skid_tag_q, skid_tag_d;
  logic             skid_ill_q, skid_ill_d;

  logic [XLEN-1:0]  dec_imm;
  logic             dec_ill;
  logic             accept;
  logic             drain;

  imm_decode #(
    .XLEN(XLEN)
  ) u_imm_decode (
    .instr_i  (in_instr),
    .immsrc_i (in_immsrc),
    .imm_o    (dec_imm),
    .illegal_o(dec_ill)
  );

  // Ready depends only on registered occupancy and reset, never on out_ready
  assign in_ready    = (state_q != OCC_TWO) && !reset;
  assign out_valid   = (state_q != OCC_EMPTY);
  assign out_imm     = main_imm_q;
  assign out_tag     = main_tag_q;
  assign out_illegal = main_ill_q;

  assign accept = in_valid && in_ready && !flush;
  assign drain  = out_valid && out_ready;

  always_comb begin
    state_d    = state_q;
    main_imm_d = main_imm_q;
    main_tag_d = main_tag_q;
    main_ill_d = main_ill_q;
    skid_imm_d = skid_imm_q;
    skid_tag_d = skid_tag_q;
    skid_ill_d = skid_ill_q;
    if (flush) begin
      state_d = OCC_EMPTY;
    end else begin
      case (state_q)
        OCC_EMPTY: begin
          if (accept) begin
            state_d    = OCC_ONE;
            main_imm_d = dec_imm;
            main_tag_d = in_tag;
            main_ill_d = dec_ill;
          end
        end
        OCC_ONE: begin
          if (accept && drain) begin
            main_imm_d = dec_imm;
            main_tag_d = in_tag;
            main_ill_d = dec_ill;
          end else if (accept) begin
            state_d    = OCC_TWO;
            skid_imm_d = dec_imm;
            skid_tag_d = in_tag;
            skid_ill_d = dec_ill;
          end else if (drain) begin
            state_d = OCC_EMPTY;
          end
        end
        OCC_TWO: begin
          // Oldest entry leaves; skid becomes the head
          if (drain) begin
            state_d    = OCC_ONE;
            main_imm_d = skid_imm_q;
            main_tag_d = skid_tag_q;
            main_ill_d = skid_ill_q;
          end
        end
        default: state_d = OCC_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= OCC_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_imm_q <= '0;
      main_tag_q <= '0;
      main_ill_q <= 1'b0;
      skid_imm_q <= '0;
      skid_tag_q <= '0;
      skid_ill_q <= 1'b0;
    end else begin
      main_imm_q <= main_imm_d;
      main_tag_q <= main_tag_d;
      main_ill_q <= main_ill_d;
      skid_imm_q <= skid_imm_d;
      skid_tag_q <= skid_tag_d;
      skid_ill_q <= skid_ill_d;
    end
  end

endmodule

// File: tb/tb_extend_pipe.sv
// Bench for extend_pipe: directed vectors plus random traffic against a queue-based reference model.
module tb_extend_pipe;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [24:0] in_instr;
  logic [2:0]  in_immsrc;
  logic [31:0] in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_imm;
  logic [31:0] out_tag;
  logic        out_illegal;

  logic        in_ready64;
  logic        out_valid64;
  logic [63:0] out_imm64;
  logic [31:0] out_tag64;
  logic        out_illegal64;

  extend_pipe #(.XLEN(32), .TAG_W(32)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_immsrc(in_immsrc), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_imm(out_imm), .out_tag(out_tag), .out_illegal(out_illegal)
  );

  extend_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64),
    .in_instr(in_instr), .in_immsrc(in_immsrc), .in_tag(in_tag),
    .out_valid(out_valid64), .out_ready(out_ready),
    .out_imm(out_imm64), .out_tag(out_tag64), .out_illegal(out_illegal64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] imm;
    logic [31:0] tag;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int   errors    = 0;
  int   checks    = 0;
  bit   rst_clean = 1'b1;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // Immediate value from the ISA field definitions, as a signed 64-bit offset
  function automatic void ref_imm(input logic [31:0] ins, input logic [2:0] src,
                                  output logic [63:0] v, output logic ill);
    longint r;
    int     si;
    si  = int'(ins);
    r   = 0;
    ill = 1'b0;
    case (src)
      3'd0: r = longint'(si >>> 20);
      3'd1: r = longint'(si >>> 25) * 32 + longint'((ins >> 7) & 32'h1f);
      3'd2: begin
        r = ins[31] ? -4096 : 0;
        r += longint'(ins[7]) * 2048;
        r += longint'((ins >> 25) & 32'h3f) * 32;
        r += longint'((ins >> 8) & 32'hf) * 2;
      end
      3'd3: begin
        r = ins[31] ? -1048576 : 0;
        r += longint'((ins >> 12) & 32'hff) * 4096;
        r += longint'(ins[20]) * 2048;
        r += longint'((ins >> 21) & 32'h3ff) * 2;
      end
      3'd4: r = longint'(int'(ins & 32'hfffff000));
`ifdef EXTEND_PIPE_CSR_UIMM_EN
      3'd5: r = longint'((ins >> 15) & 32'h1f);
`endif
      default: ill = 1'b1;
    endcase
    v = 64'(r);
  endfunction

  task automatic drive(input bit v, input logic [31:0] ins, input logic [2:0] src,
                       input logic [31:0] tag, input bit ordy);
    in_valid  = v;
    in_instr  = ins[31:7];
    in_immsrc = src;
    in_tag    = tag;
    out_ready = ordy;
  endtask

  // One clock: check outputs against the model, then advance the model on the edge
  task automatic cyc();
    bit   acc;
    bit   drn;
    exp_t e;
    @(negedge clk);
    chk("in_ready", 64'(in_ready), 64'(q.size() < 2 && !reset));
    chk("in_ready64", 64'(in_ready64), 64'(q.size() < 2 && !reset));
    chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
    chk("out_valid64", 64'(out_valid64), 64'(q.size() != 0));
    if (q.size() != 0) begin
      chk("out_imm", 64'(out_imm), 64'(q[0].imm[31:0]));
      chk("out_imm64", out_imm64, q[0].imm);
      chk("out_tag", 64'(out_tag), 64'(q[0].tag));
      chk("out_tag64", 64'(out_tag64), 64'(q[0].tag));
      chk("out_illegal", 64'(out_illegal), 64'(q[0].ill));
      chk("out_illegal64", 64'(out_illegal64), 64'(q[0].ill));
    end else if (rst_clean) begin
      chk("rst_imm", 64'(out_imm), 64'd0);
      chk("rst_tag", 64'(out_tag), 64'd0);
      chk("rst_illegal", 64'(out_illegal), 64'd0);
    end
    acc = in_valid && (q.size() < 2) && !reset && !flush;
    drn = out_ready && (q.size() != 0);
    ref_imm({in_instr, 7'b0}, in_immsrc, e.imm, e.ill);
    e.tag = in_tag;
    @(posedge clk);
    if (reset) begin
      q.delete();
      rst_clean = 1'b1;
    end else if (flush) begin
      q.delete();
    end else begin
      if (drn) void'(q.pop_front());
      if (acc) begin
        q.push_back(e);
        rst_clean = 1'b0;
      end
    end
    #1;
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    drive(1'b0, 32'h0, 3'd0, 32'h0, 1'b0);
    cyc();
    cyc();
    reset = 1'b0;

    // Directed formats, full throughput with out_ready high
    drive(1'b1, 32'hFFF00093, 3'd0, 32'h100, 1'b1); cyc();
    chk("addi_imm", 64'(out_imm), 64'hFFFFFFFF);
    chk("addi_illegal", 64'(out_illegal), 64'd0);
    drive(1'b1, 32'hFE000EE3, 3'd2, 32'h101, 1'b1); cyc();
    chk("beq_imm", 64'(out_imm), 64'hFFFFFFFC);
    drive(1'b1, 32'h0080006F, 3'd3, 32'h102, 1'b1); cyc();
    chk("jal_imm", 64'(out_imm), 64'h00000008);
    drive(1'b1, 32'h123450B7, 3'd4, 32'h103, 1'b1); cyc();
    chk("lui_imm", 64'(out_imm), 64'h12345000);
    drive(1'b1, 32'h800000B7, 3'd4, 32'h104, 1'b1); cyc();
    chk("lui_neg_imm", 64'(out_imm), 64'h80000000);
    chk("lui_neg_imm64", out_imm64, 64'hFFFFFFFF80000000);
    drive(1'b1, 32'h000F8073, 3'd5, 32'h105, 1'b1); cyc();
`ifdef EXTEND_PIPE_CSR_UIMM_EN
    chk("csr_imm", 64'(out_imm), 64'h1F);
    chk("csr_illegal", 64'(out_illegal), 64'd0);
`else
    chk("csr_imm", 64'(out_imm), 64'h0);
    chk("csr_illegal", 64'(out_illegal), 64'd1);
`endif
    drive(1'b1, 32'hFFFFFFFF, 3'd7, 32'h106, 1'b1); cyc();
    chk("rsvd_imm", 64'(out_imm), 64'h0);
    chk("rsvd_illegal", 64'(out_illegal), 64'd1);
    drive(1'b0, 32'h0, 3'd0, 32'h0, 1'b1); cyc();

    // Backpressure: third offer is refused until a slot frees
    drive(1'b1, 32'h00100093, 3'd0, 32'd1, 1'b0); cyc();
    drive(1'b1, 32'h00200093, 3'd0, 32'd2, 1'b0); cyc();
    drive(1'b1, 32'h00300093, 3'd0, 32'd3, 1'b0); cyc();
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    chk("bp_head_tag", 64'(out_tag), 64'd1);
    out_ready = 1'b1; cyc();
    chk("bp_tag2", 64'(out_tag), 64'd2);
    cyc();
    chk("bp_tag3", 64'(out_tag), 64'd3);
    drive(1'b0, 32'h0, 3'd0, 32'h0, 1'b1); cyc();
    chk("bp_empty", 64'(out_valid), 64'd0);

    // Flush while full with a new offer pending
    drive(1'b1, 32'h01000093, 3'd0, 32'h10, 1'b0); cyc();
    drive(1'b1, 32'h01100093, 3'd0, 32'h11, 1'b0); cyc();
    flush = 1'b1;
    drive(1'b1, 32'h01200093, 3'd0, 32'h12, 1'b0); cyc();
    flush = 1'b0;
    drive(1'b0, 32'h0, 3'd0, 32'h0, 1'b0);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    cyc();

    // Reset in the middle of holding one entry
    drive(1'b1, 32'hABC00093, 3'd0, 32'h20, 1'b0); cyc();
    drive(1'b0, 32'h0, 3'd0, 32'h0, 1'b0);
    reset = 1'b1; cyc();
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_out_imm", 64'(out_imm), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
    cyc();
    reset = 1'b0; #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    cyc();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      flush = ($urandom_range(0, 19) == 0);
      drive($urandom_range(0, 9) < 7, $urandom, 3'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 9) < 6);
      cyc();
    end

    reset = 1'b0;
    flush = 1'b0;
    drive(1'b0, 32'h0, 3'd0, 32'h0, 1'b1);
    repeat (4) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
